// File: rtl/gcd_pkg.sv
// Shared types and constants for the binary-GCD responder and its benches.
// Holds the FSM state encoding and the worst-case latency bound.
package gcd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SHIFT,
        NORM,
        STEP,
        DONE
    } gcd_state_t;

    localparam int GCD_WIDTH = 32;

    function automatic int gcd_max_lat(input int w);
        return 4 * w + 4;
    endfunction

    localparam int GCD_MAX_LAT = gcd_max_lat(GCD_WIDTH);

endpackage

// File: rtl/gcd_sub_step.sv
// Subtract step of the binary GCD: min(x,y), |x-y| and an equality flag.
// Kept separate so reference and faulty cores share this datapath slice.
module gcd_sub_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    output logic [WIDTH-1:0] min_o,
    output logic [WIDTH-1:0] diff_o,
    output logic             eq_o
);

    logic x_lt_y;

    assign x_lt_y = x_i < y_i;
    assign min_o  = x_lt_y ? x_i : y_i;
    assign diff_o = x_lt_y ? (y_i - x_i) : (x_i - y_i);
    assign eq_o   = x_i == y_i;

endmodule

// File: rtl/gcd_stein.sv
// Binary (Stein) GCD responder: shift/compare/subtract only, no divider.
// All outputs registered; done is a level held until the next accept.
module gcd_stein
    import gcd_pkg::*;
#(
    parameter int WIDTH = GCD_WIDTH,
    parameter int KW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             busy
);

    gcd_state_t       state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] sub_min;
    logic [WIDTH-1:0] sub_diff;
    logic             sub_eq;

    gcd_sub_step #(.WIDTH(WIDTH)) u_sub (
        .x_i    (x_q),
        .y_i    (y_q),
        .min_o  (sub_min),
        .diff_o (sub_diff),
        .eq_o   (sub_eq)
    );

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        k_d      = k_q;
        result_d = result_q;
        done_d   = done_q;
        busy_d   = busy_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    x_d     = a;
                    y_d     = b;
                    k_d     = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (x_q == '0) begin
                    result_d = y_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else if (y_q == '0) begin
                    result_d = x_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + 1'b1;
                end else begin
                    state_d = NORM;
                end
            end
            NORM: begin
                if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else begin
                    state_d = STEP;
                end
            end
            STEP: begin
                // x stays odd here, so |x-y| of two odds is even and y shrinks
                if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (sub_eq) begin
                    result_d = x_q << k_q;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = DONE;
                end else begin
                    x_d = sub_min;
                    y_d = sub_diff;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            k_q      <= k_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_gcd_stein.sv
// Directed bench for gcd_stein against a Euclid reference model.
// A negedge monitor checks result whenever done is high.
module tb_gcd_stein;
    import gcd_pkg::*;

    localparam int W   = 32;
    localparam int LIM = GCD_MAX_LAT + 4;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] result;
    logic         done;
    logic         busy;

    logic [W-1:0] exp_res;
    logic         mon_en;
    int           errors;
    int           checks;

    gcd_stein #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a_r),
        .b       (b_r),
        .result  (result),
        .done    (done),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mgcd(input logic [W-1:0] x,
                                          input logic [W-1:0] y);
        logic [W-1:0] p, q, t;
        p = x;
        q = y;
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic chk(input string name, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h) required %0d (0x%h)",
                     name, act, act, req, req);
        end
    endtask

    // Reference monitor: any cycle done is high, result must match model
    always @(negedge clk) begin
        if (mon_en && reset_n) begin
            chk("busy_done_excl", {31'd0, busy & done}, '0);
            if (done) chk("mon_result", result, exp_res);
        end
    end

    task automatic wait_done(input string name, inout int lat);
        while (!done && lat < LIM) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s_timeout: got done=0 after %0d cycles required done=1",
                     name, lat);
        end
    endtask

    task automatic req(input string name, input logic [W-1:0] ta,
                       input logic [W-1:0] tb_, output int lat);
        @(negedge clk);
        a_r   = ta;
        b_r   = tb_;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        exp_res = mgcd(ta, tb_);
        chk({name, "_done_low"}, {31'd0, done}, '0);
        chk({name, "_busy_high"}, {31'd0, busy}, 32'd1);
        lat = 0;
        wait_done(name, lat);
    endtask

    int lat;
    logic [W-1:0] q;

    initial begin
        errors  = 0;
        checks  = 0;
        mon_en  = 1'b0;
        exp_res = '0;
        start   = 1'b0;
        a_r     = '0;
        b_r     = '0;
        reset_n = 1'b0;

        chk("model_48_18", mgcd(32'd48, 32'd18), 32'd6);
        chk("model_0_0", mgcd(32'd0, 32'd0), 32'd0);
        chk("model_0_5", mgcd(32'd0, 32'd5), 32'd5);
        chk("model_7_13", mgcd(32'd7, 32'd13), 32'd1);

        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", result, '0);
        chk("rst_done", {31'd0, done}, '0);
        chk("rst_busy", {31'd0, busy}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        mon_en  = 1'b1;

        req("g48_18", 32'd48, 32'd18, lat);
        chk("g48_18_lat", lat, 32'd10);
        chk("g48_18_res", result, 32'd6);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("hold_done", {31'd0, done}, 32'd1);
            chk("hold_res", result, 32'd6);
        end

        req("g7_13", 32'd7, 32'd13, lat);
        chk("g7_13_res", result, 32'd1);
        chk("g7_13_inlim", {31'd0, lat <= GCD_MAX_LAT}, 32'd1);

        req("g0_5", 32'd0, 32'd5, lat);
        chk("g0_5_res", result, 32'd5);
        chk("g0_5_lat", lat, 32'd1);

        req("g0_0", 32'd0, 32'd0, lat);
        chk("g0_0_res", result, 32'd0);
        chk("g0_0_lat", lat, 32'd1);

        req("g9_0", 32'd9, 32'd0, lat);
        chk("g9_0_res", result, 32'd9);
        chk("g9_0_lat", lat, 32'd1);

        req("gpow2", 32'h8000_0000, 32'h4000_0000, lat);
        chk("gpow2_res", result, 32'h4000_0000);

        req("gmax", 32'hFFFF_FFFF, 32'hFFFF_FFFE, lat);
        chk("gmax_res", result, 32'd1);
        chk("gmax_inlim", {31'd0, lat <= GCD_MAX_LAT}, 32'd1);

        req("g1071_462", 32'd1071, 32'd462, lat);
        chk("g1071_462_res", result, 32'd21);

        // start while busy must be ignored
        @(negedge clk);
        a_r   = 32'd48;
        b_r   = 32'd18;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        exp_res = 32'd6;
        lat     = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            lat++;
        end
        @(negedge clk);
        a_r   = 32'd5;
        b_r   = 32'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat++;
        start = 1'b0;
        chk("ign_busy", {31'd0, busy}, 32'd1);
        wait_done("ign", lat);
        chk("ign_res", result, 32'd6);
        chk("ign_lat", lat, 32'd10);

        // back-to-back accept from DONE
        req("b2b", 32'd12, 32'd8, lat);
        chk("b2b_res", result, 32'd4);

        // asynchronous reset while in STEP
        @(negedge clk);
        a_r   = 32'd48;
        b_r   = 32'd18;
        start = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        exp_res = 32'd6;
        repeat (8) @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_result", result, '0);
        chk("arst_done", {31'd0, done}, '0);
        chk("arst_busy", {31'd0, busy}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_idle_done", {31'd0, done}, '0);
        chk("arst_idle_busy", {31'd0, busy}, '0);

        req("g9_6", 32'd9, 32'd6, lat);
        chk("g9_6_res", result, 32'd3);

        repeat (2) @(posedge clk);
        q = result;
        chk("final_hold", q, 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
